// File: rtl/cpu_bus_pkg.sv
// Shared encodings for the CPU-side sram-like bridges: FSM states and access sizes.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

endpackage

// File: rtl/cpu_bus_bridges.sv
// Integration: instruction-fetch bridge (read-only) and data bridge side by side.
module cpu_bus_bridges
  import cpu_bus_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int ALIGN_CHK = 1
) (
  input  logic                clk,
  input  logic                resetn,
  // instruction side
  input  logic                inst_req,
  input  logic [1:0]          inst_size,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic                inst_hold,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_stall,
  output logic                inst_addr_err,
  output logic                ib_req,
  output logic                ib_wr,
  output logic [1:0]          ib_size,
  output logic [ADDR_W-1:0]   ib_addr,
  output logic [DATA_W-1:0]   ib_wdata,
  output logic [DATA_W/8-1:0] ib_wstrb,
  input  logic                ib_addr_ok,
  input  logic                ib_data_ok,
  input  logic [DATA_W-1:0]   ib_rdata,
  // data side
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic                data_hold,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_stall,
  output logic                data_addr_err,
  output logic                db_req,
  output logic                db_wr,
  output logic [1:0]          db_size,
  output logic [ADDR_W-1:0]   db_addr,
  output logic [DATA_W-1:0]   db_wdata,
  output logic [DATA_W/8-1:0] db_wstrb,
  input  logic                db_addr_ok,
  input  logic                db_data_ok,
  input  logic [DATA_W-1:0]   db_rdata
);

  sram_like_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ALIGN_CHK(ALIGN_CHK)) u_inst (
    .clk, .resetn,
    .cpu_req(inst_req), .cpu_wr(1'b0), .cpu_size(inst_size), .cpu_addr(inst_addr),
    .cpu_wdata('0), .cpu_hold(inst_hold), .cpu_rdata(inst_rdata), .cpu_stall(inst_stall),
    .cpu_addr_err(inst_addr_err),
    .req(ib_req), .wr(ib_wr), .size(ib_size), .addr(ib_addr), .wdata(ib_wdata), .wstrb(ib_wstrb),
    .addr_ok(ib_addr_ok), .data_ok(ib_data_ok), .rdata(ib_rdata)
  );

  sram_like_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ALIGN_CHK(ALIGN_CHK)) u_data (
    .clk, .resetn,
    .cpu_req(data_req), .cpu_wr(data_wr), .cpu_size(data_size), .cpu_addr(data_addr),
    .cpu_wdata(data_wdata), .cpu_hold(data_hold), .cpu_rdata(data_rdata), .cpu_stall(data_stall),
    .cpu_addr_err(data_addr_err),
    .req(db_req), .wr(db_wr), .size(db_size), .addr(db_addr), .wdata(db_wdata), .wstrb(db_wstrb),
    .addr_ok(db_addr_ok), .data_ok(db_data_ok), .rdata(db_rdata)
  );

endmodule

// File: rtl/sram_like_bridge_lane_mask.sv
// Byte-lane strobe and alignment check for one access (size + low address bits).
module lane_mask
  import cpu_bus_pkg::*;
#(
  parameter int NB    = 4,
  parameter int OFF_W = $clog2(NB)
) (
  input  logic [1:0]       size,
  input  logic [OFF_W-1:0] off,
  output logic [NB-1:0]    strb,
  output logic             misalign
);

  logic [OFF_W-1:0] low_mask;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign strb[i] = (i >= int'(off)) && (i < int'(off) + (1 << size));
  end

  // dword on a 4-lane bus can never be aligned
  assign low_mask = OFF_W'((32'd1 << size) - 32'd1);
  assign misalign = ((off & low_mask) != '0) || ((size == SZ_DWORD) && (NB == 4));

endmodule

// File: rtl/sram_like_bridge.sv
// CPU-to-sram-like bus bridge: one outstanding access, bus fields driven from latched registers.
module sram_like_bridge
  import cpu_bus_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int ALIGN_CHK = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cpu_req,
  input  logic                cpu_wr,
  input  logic [1:0]          cpu_size,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic                cpu_hold,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_stall,
  output logic                cpu_addr_err,
  output logic                req,
  output logic                wr,
  output logic [1:0]          size,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic                addr_ok,
  input  logic                data_ok,
  input  logic [DATA_W-1:0]   rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  state_e              state_q, state_d;
  logic                accept, mis, mis_eff;
  logic [NB-1:0]       strb;
  logic [DATA_W-1:0]   wdata_rep;
  logic                wr_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [NB-1:0]       wstrb_q;

  lane_mask #(.NB(NB)) u_lane_mask (
    .size     (cpu_size),
    .off      (cpu_addr[OFF_W-1:0]),
    .strb     (strb),
    .misalign (mis)
  );

  assign mis_eff = (ALIGN_CHK != 0) && mis;

  // low 2^size bytes of the CPU data repeated across every lane
  always_comb begin
    wdata_rep = '0;
    for (int i = 0; i < NB; i++)
      wdata_rep[i*8 +: 8] = cpu_wdata[(i & ((1 << cpu_size) - 1))*8 +: 8];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    cpu_stall    = 1'b0;
    cpu_addr_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          if (mis_eff) begin
            cpu_addr_err = resetn;
          end else begin
            accept    = 1'b1;
            cpu_stall = 1'b1;
            state_d   = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        cpu_stall = 1'b1;
        if (addr_ok) state_d = ST_DATA;
      end
      // data_ok only counts here, so one coincident with addr_ok is dropped
      ST_DATA: begin
        cpu_stall = 1'b1;
        if (data_ok) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!cpu_hold) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        wr_q    <= cpu_wr;
        size_q  <= cpu_size;
        addr_q  <= cpu_addr;
        wdata_q <= wdata_rep;
        wstrb_q <= cpu_wr ? strb : '0;
      end
      if ((state_q == ST_DATA) && data_ok && !wr_q) rdata_q <= rdata;
    end
  end

  assign req       = (state_q == ST_ADDR);
  assign wr        = wr_q;
  assign size      = size_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_sram_like_bridge.sv
// Directed bench for sram_like_bridge (DATA_W=32, ALIGN_CHK=1) with a delay-programmable bus responder.
module tb_sram_like_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_req, cpu_wr, cpu_hold;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall, cpu_addr_err;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        addr_ok, data_ok;
  logic [31:0] bus_rdata;

  int errors = 0;
  int checks = 0;

  // bus responder controls
  int   a_dly = 0, d_dly = 0, acnt = 0, dcnt = 0;
  logic in_data = 1'b0, early_dok = 1'b0, stray_dok = 1'b0;

  // per-transaction observations
  int          sc, rc;
  logic        addr_moved;
  logic [31:0] a_seen, wd_seen;
  logic [3:0]  strb_seen;
  logic        wr_seen;
  logic [1:0]  sz_seen;

  always #5 clk = ~clk;

  sram_like_bridge #(.DATA_W(32), .ADDR_W(32), .ALIGN_CHK(1)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_hold(cpu_hold), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .cpu_addr_err(cpu_addr_err),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(bus_rdata)
  );

  assign addr_ok = req && (acnt == a_dly);
  assign data_ok = (in_data && (dcnt == d_dly)) || (early_dok && req && addr_ok) || stray_dok;

  always @(posedge clk) begin
    if (!resetn) begin
      acnt    <= 0;
      dcnt    <= 0;
      in_data <= 1'b0;
    end else begin
      acnt <= req ? acnt + 1 : 0;
      if (req && addr_ok) begin
        in_data <= 1'b1;
        dcnt    <= 0;
      end else if (data_ok) begin
        in_data <= 1'b0;
      end else if (in_data) begin
        dcnt <= dcnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns at the mid-cycle of the first non-stalled cycle.
  task automatic txn(input logic w, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input int ad, input int dd, input logic early);
    a_dly = ad; d_dly = dd; early_dok = early;
    cpu_wr = w; cpu_size = sz; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
    sc = 0; rc = 0; addr_moved = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (req) begin
        if (rc == 0) begin
          a_seen = addr; wd_seen = wdata; strb_seen = wstrb; wr_seen = wr; sz_seen = size;
        end else if (addr !== a_seen) begin
          addr_moved = 1'b1;
        end
        rc++;
      end
      if (cpu_stall) sc++;
      else break;
      @(posedge clk); #1;
    end
    chk("txn_released", {31'd0, cpu_stall}, 32'd0);
  endtask

  task automatic txn_end();
    cpu_req = 1'b0; early_dok = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    resetn = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_hold = 1'b0;
    cpu_size = 2'd0; cpu_addr = '0; cpu_wdata = '0; bus_rdata = '0;
    #12;
    chk("rst_req",   {31'd0, req}, 32'd0);
    chk("rst_wr",    {31'd0, wr}, 32'd0);
    chk("rst_wstrb", {28'd0, wstrb}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_err",   {31'd0, cpu_addr_err}, 32'd0);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;

    // word read, immediate handshakes
    bus_rdata = 32'hDEADBEEF;
    txn(1'b0, 2'd2, 32'h100, 32'h0, 0, 0, 1'b0);
    chk("rd_stall_cycles", sc, 3);
    chk("rd_req_cycles", rc, 1);
    chk("rd_addr", a_seen, 32'h100);
    chk("rd_wr", {31'd0, wr_seen}, 32'd0);
    chk("rd_wstrb", {28'd0, strb_seen}, 32'd0);
    chk("rd_rdata", cpu_rdata, 32'hDEADBEEF);
    txn_end();

    // byte write to lane 3
    bus_rdata = 32'h12345678;
    txn(1'b1, 2'd0, 32'h203, 32'h000000A5, 0, 0, 1'b0);
    chk("wb_wstrb", {28'd0, strb_seen}, 32'h8);
    chk("wb_wdata", wd_seen, 32'hA5A5A5A5);
    chk("wb_wr", {31'd0, wr_seen}, 32'd1);
    chk("wb_size", {30'd0, sz_seen}, 32'd0);
    chk("wb_stall_cycles", sc, 3);
    chk("wb_rdata_kept", cpu_rdata, 32'hDEADBEEF);
    txn_end();

    // half write, upper half
    txn(1'b1, 2'd1, 32'h102, 32'h1234ABCD, 0, 0, 1'b0);
    chk("wh_wstrb", {28'd0, strb_seen}, 32'hC);
    chk("wh_wdata", wd_seen, 32'hABCDABCD);
    txn_end();

    // word write
    txn(1'b1, 2'd2, 32'h104, 32'hCAFEF00D, 0, 0, 1'b0);
    chk("ww_wstrb", {28'd0, strb_seen}, 32'hF);
    chk("ww_wdata", wd_seen, 32'hCAFEF00D);
    chk("ww_rdata_kept", cpu_rdata, 32'hDEADBEEF);
    txn_end();

    // misaligned half read
    cpu_wr = 1'b0; cpu_size = 2'd1; cpu_addr = 32'h101; cpu_req = 1'b1;
    @(negedge clk);
    chk("mis_err", {31'd0, cpu_addr_err}, 32'd1);
    chk("mis_stall", {31'd0, cpu_stall}, 32'd0);
    chk("mis_req", {31'd0, req}, 32'd0);
    @(posedge clk); #1 cpu_req = 1'b0;
    @(negedge clk);
    chk("mis_err_pulse", {31'd0, cpu_addr_err}, 32'd0);
    chk("mis_req_after", {31'd0, req}, 32'd0);
    // dword is never legal on a 32-bit bus
    @(posedge clk); #1 cpu_size = 2'd3; cpu_addr = 32'h0; cpu_req = 1'b1;
    @(negedge clk);
    chk("dword_err", {31'd0, cpu_addr_err}, 32'd1);
    chk("dword_stall", {31'd0, cpu_stall}, 32'd0);
    @(posedge clk); #1 cpu_req = 1'b0;
    @(negedge clk);
    chk("dword_req", {31'd0, req}, 32'd0);
    @(posedge clk); #1;

    // slow bus: addr_ok after 4 waits, data_ok after 2 more
    bus_rdata = 32'h0BADF00D;
    txn(1'b0, 2'd2, 32'h200, 32'h0, 4, 2, 1'b0);
    chk("slow_stall_cycles", sc, 9);
    chk("slow_req_cycles", rc, 5);
    chk("slow_addr_stable", {31'd0, addr_moved}, 32'd0);
    chk("slow_rdata", cpu_rdata, 32'h0BADF00D);

    // hold in DONE for 3 cycles while the CPU presents a different request
    cpu_hold = 1'b1; cpu_addr = 32'h300; bus_rdata = 32'h55555555;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_rdata", cpu_rdata, 32'h0BADF00D);
      chk("hold_req", {31'd0, req}, 32'd0);
      chk("hold_stall", {31'd0, cpu_stall}, 32'd0);
    end
    cpu_hold = 1'b0; cpu_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("unhold_req", {31'd0, req}, 32'd0);
    chk("unhold_stall", {31'd0, cpu_stall}, 32'd0);
    @(posedge clk); #1;

    // data_ok coincident with addr_ok must be ignored
    bus_rdata = 32'h13579BDF;
    txn(1'b0, 2'd2, 32'h010, 32'h0, 0, 1, 1'b1);
    chk("early_dok_stall", sc, 4);
    chk("early_dok_rdata", cpu_rdata, 32'h13579BDF);
    txn_end();

    // reset during DATA, then a stray data_ok in IDLE
    bus_rdata = 32'h77777777; a_dly = 0; d_dly = 5;
    cpu_wr = 1'b0; cpu_size = 2'd2; cpu_addr = 32'h100; cpu_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_in_data", {31'd0, cpu_stall}, 32'd1);
    resetn = 1'b0; cpu_req = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, req}, 32'd0);
    chk("mid_rst_rdata", cpu_rdata, 32'd0);
    chk("mid_rst_stall", {31'd0, cpu_stall}, 32'd0);
    @(posedge clk); #1 resetn = 1'b1;
    stray_dok = 1'b1; bus_rdata = 32'h99999999;
    @(posedge clk); #1 stray_dok = 1'b0;
    @(negedge clk);
    chk("stray_rdata", cpu_rdata, 32'd0);
    chk("stray_req", {31'd0, req}, 32'd0);
    chk("stray_stall", {31'd0, cpu_stall}, 32'd0);
    @(posedge clk); #1;

    // bridge usable again after the abandoned access
    bus_rdata = 32'h2468ACE0;
    txn(1'b0, 2'd2, 32'h104, 32'h0, 0, 0, 1'b0);
    chk("post_rst_stall", sc, 3);
    chk("post_rst_rdata", cpu_rdata, 32'h2468ACE0);
    txn_end();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
